// File: rtl/ethpkg.sv
// Shared definitions for the Ethernet transmit buffer: FSM encoding, frame limits, buffer geometry.
// PAD exists only when ETHTX_PAD_EN is defined.
package ethpkg;

    localparam logic [10:0] MAXB_DEF  = 11'd1514;
    localparam logic [10:0] MIN_LEN   = 11'd60;
    localparam int          BUF_DEPTH = 512;
    localparam int          ADDR_W    = $clog2(BUF_DEPTH);
    // Padding zeroes the first 64 bytes of the buffer (entries 0..15).
    localparam logic [9:0]  PAD_END   = 10'd15;

    typedef enum logic [2:0] {
        FILL  = 3'd0,
`ifdef ETHTX_PAD_EN
        PAD   = 3'd1,
`endif
        ARM   = 3'd2,
        WDONE = 3'd3,
        WREL  = 3'd4
    } state_t;

endpackage

// File: rtl/ethtxbuf_if.sv
// Bus between the frame writer, the transmit buffer and the sender.
// slave is the buffer side, master the writer/sender side.
interface ethtxbuf_if;
    import ethpkg::*;

    logic              wr_stb;
    logic [15:0]       wr_data;
    logic              wr_last;
    logic              wr_odd;
    logic              wr_skip;
    logic              wr_rdy;
    logic [ADDR_W-1:0] txbaddr;
    logic [31:0]       txbdata;
    logic [10:0]       txcntb;
    logic              skipb;
    logic              txena;
    logic              txdone;
    logic              tx_ok;
    logic              tx_ovf;

    modport slave (
        input  wr_stb, wr_data, wr_last, wr_odd, wr_skip, txbaddr, txdone,
        output wr_rdy, txbdata, txcntb, skipb, txena, tx_ok, tx_ovf
    );

    modport master (
        output wr_stb, wr_data, wr_last, wr_odd, wr_skip, txbaddr, txdone,
        input  wr_rdy, txbdata, txcntb, skipb, txena, tx_ok, tx_ovf
    );

endinterface

// File: rtl/ethtxram.sv
// 512x32 frame buffer: independent 16-bit half write enables, one registered read port.
// Contents are deliberately not reset.
module ethtxram
    import ethpkg::*;
(
    input  logic              clk,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (we[0]) mem[waddr][15:0]  <= wdata[15:0];
        if (we[1]) mem[waddr][31:16] <= wdata[31:16];
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ethtxbuf.sv
// Ethernet transmit buffer: collects a frame as 16-bit words, then hands it to the sender.
// Define ETHTX_PAD_EN to zero-pad short frames up to the 60-byte minimum.
module ethtxbuf
    import ethpkg::*;
#(
    parameter logic [10:0] MAXB = MAXB_DEF
)(
    input  logic       clk,
    input  logic       clr_n,
    ethtxbuf_if.slave  bus
);

    state_t            state;
    logic [10:0]       wcnt;
    logic              skip_q;
    logic              drop;
    logic              rdy;
    logic              txena_q;
    logic              tx_ok_q;
    logic              tx_ovf_q;
    logic [10:0]       txcntb_q;
`ifdef ETHTX_PAD_EN
    logic [10:0]       nb;
    logic [9:0]        pad_ptr;
    logic              pad_hi;
`endif

    logic              accept;
    logic              first;
    logic              skip_eff;
    logic [10:0]       wnext;
    logic [11:0]       nb_new;
    logic              over;
    logic [1:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       rdata;

    // Byte count as it would stand once the word on the bus is taken.
    assign accept   = (state == FILL) && bus.wr_stb && !drop;
    assign first    = (wcnt == 11'd0);
    assign skip_eff = first ? bus.wr_skip : skip_q;
    assign wnext    = wcnt + 11'd1;
    assign nb_new   = {wnext, 1'b0} - 12'(bus.wr_last & bus.wr_odd) - 12'(skip_eff);
    assign over     = nb_new > {1'b0, MAXB};

    always_comb begin
        ram_we    = 2'b00;
        ram_addr  = wcnt[ADDR_W:1];
        ram_wdata = {bus.wr_data, bus.wr_data};
        if (accept && !over) ram_we = wcnt[0] ? 2'b10 : 2'b01;
`ifdef ETHTX_PAD_EN
        if (state == PAD && pad_ptr <= PAD_END) begin
            ram_we    = pad_hi ? 2'b10 : 2'b11;
            ram_addr  = pad_ptr[ADDR_W-1:0];
            ram_wdata = '0;
        end
`endif
    end

    ethtxram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_addr),
        .wdata (ram_wdata),
        .raddr (bus.txbaddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= FILL;
            wcnt     <= '0;
            skip_q   <= 1'b0;
            drop     <= 1'b0;
            rdy      <= 1'b1;
            txena_q  <= 1'b0;
            tx_ok_q  <= 1'b0;
            tx_ovf_q <= 1'b0;
            txcntb_q <= '0;
`ifdef ETHTX_PAD_EN
            nb       <= '0;
            pad_ptr  <= '0;
            pad_hi   <= 1'b0;
`endif
        end else begin
            tx_ok_q <= 1'b0;
            case (state)
                FILL: if (bus.wr_stb) begin
                    if (drop) begin
                        // Rest of an oversize frame: swallow through its last word.
                        if (bus.wr_last) drop <= 1'b0;
                    end else if (over) begin
                        tx_ovf_q <= 1'b1;
                        wcnt     <= '0;
                        skip_q   <= 1'b0;
                        drop     <= !bus.wr_last;
                    end else begin
                        if (first) begin
                            skip_q   <= bus.wr_skip;
                            tx_ovf_q <= 1'b0;
                        end
                        if (!bus.wr_last) begin
                            wcnt <= wnext;
                        end else if (nb_new == 12'd0) begin
                            // Nothing left to send once the skipped byte is removed.
                            wcnt   <= '0;
                            skip_q <= 1'b0;
                        end else begin
                            wcnt     <= wnext;
                            txcntb_q <= 11'h000 - nb_new[10:0];
                            rdy      <= 1'b0;
`ifdef ETHTX_PAD_EN
                            nb       <= nb_new[10:0];
                            pad_ptr  <= wnext[10:1];
                            pad_hi   <= wnext[0];
                            state    <= PAD;
`else
                            txena_q  <= 1'b1;
                            state    <= ARM;
`endif
                        end
                    end
                end
`ifdef ETHTX_PAD_EN
                PAD: begin
                    if (pad_ptr <= PAD_END) begin
                        pad_ptr <= pad_ptr + 10'd1;
                        pad_hi  <= 1'b0;
                    end else begin
                        if (nb < MIN_LEN) begin
                            nb       <= MIN_LEN;
                            txcntb_q <= 11'h000 - MIN_LEN;
                        end
                        txena_q <= 1'b1;
                        state   <= ARM;
                    end
                end
`endif
                ARM: state <= WDONE;
                WDONE: if (bus.txdone) begin
                    txena_q <= 1'b0;
                    state   <= WREL;
                end
                WREL: if (!bus.txdone) begin
                    tx_ok_q <= 1'b1;
                    wcnt    <= '0;
                    skip_q  <= 1'b0;
                    rdy     <= 1'b1;
                    state   <= FILL;
                end
                default: begin
                    rdy   <= 1'b1;
                    state <= FILL;
                end
            endcase
        end
    end

    assign bus.wr_rdy  = rdy;
    assign bus.txbdata = rdata;
    assign bus.txcntb  = txcntb_q;
    assign bus.skipb   = skip_q;
    assign bus.txena   = txena_q;
    assign bus.tx_ok   = tx_ok_q;
    assign bus.tx_ovf  = tx_ovf_q;

endmodule

// File: tb/tb_ethtxbuf.sv
// Directed bench for ethtxbuf: frame lengths, skip, odd, oversize, nb=0 drop, handshake, reset.
// Expectations follow ETHTX_PAD_EN when it is defined for the build.
module tb_ethtxbuf;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    ethtxbuf_if bus ();

    ethtxbuf dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int n, logic odd, logic skip, logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            bus.wr_stb  = 1'b1;
            bus.wr_data = base ^ 16'(k);
            bus.wr_last = (k == n - 1);
            bus.wr_odd  = odd && (k == n - 1);
            bus.wr_skip = skip && (k == 0);
            tick();
        end
        bus.wr_stb  = 1'b0;
        bus.wr_last = 1'b0;
        bus.wr_odd  = 1'b0;
        bus.wr_skip = 1'b0;
    endtask

    task automatic wait_txena(string tag);
        int n = 0;
        while (bus.txena !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk(tag, bus.txena, 1'b1);
    endtask

    task automatic rd(string tag, logic [8:0] a, logic [31:0] exp);
        bus.txbaddr = a;
        tick();
        chk(tag, bus.txbdata, exp);
    endtask

    // Sender: txdone 5 cycles after txena, held for 3 cycles.
    task automatic run_tx();
        repeat (4) tick();
        bus.txdone = 1'b1;
        tick();
        chk("txena_fall", bus.txena, 1'b0);
        tick();
        tick();
        chk("tx_ok_hold", bus.tx_ok, 1'b0);
        bus.txdone = 1'b0;
        tick();
        chk("tx_ok_pulse", bus.tx_ok, 1'b1);
        chk("rdy_back", bus.wr_rdy, 1'b1);
        tick();
        chk("tx_ok_once", bus.tx_ok, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_stb  = 1'b0;
        bus.wr_data = '0;
        bus.wr_last = 1'b0;
        bus.wr_odd  = 1'b0;
        bus.wr_skip = 1'b0;
        bus.txbaddr = '0;
        bus.txdone  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_txena", bus.txena, 1'b0);
        chk("rst_tx_ok", bus.tx_ok, 1'b0);
        chk("rst_tx_ovf", bus.tx_ovf, 1'b0);
        chk("rst_skipb", bus.skipb, 1'b0);
        chk("rst_txcntb", bus.txcntb, 11'h000);
        chk("rst_wr_rdy", bus.wr_rdy, 1'b1);
        clr_n = 1'b1;
        tick();

        // 30 words: nb=60
        send(30, 1'b0, 1'b0, 16'hA500);
        wait_txena("f30_txena");
        chk("f30_txcntb", bus.txcntb, 11'h7C4);
        chk("f30_skipb", bus.skipb, 1'b0);
        chk("f30_rdy", bus.wr_rdy, 1'b0);
        rd("f30_e0", 9'd0, 32'hA501_A500);
        rd("f30_e14", 9'd14, 32'hA51D_A51C);
        // Stray write while transmitting must be ignored
        bus.wr_stb = 1'b1; bus.wr_last = 1'b1; bus.wr_odd = 1'b1; bus.wr_data = 16'hFFFF;
        tick();
        bus.wr_stb = 1'b0; bus.wr_last = 1'b0; bus.wr_odd = 1'b0;
        chk("stray_txcntb", bus.txcntb, 11'h7C4);
        chk("stray_txena", bus.txena, 1'b1);
        rd("stray_e0", 9'd0, 32'hA501_A500);
        run_tx();

        // Skip, 40 words: nb=79
        send(40, 1'b0, 1'b1, 16'hA500);
        wait_txena("f40_txena");
        chk("f40_skipb", bus.skipb, 1'b1);
        chk("f40_txcntb", bus.txcntb, 11'h7B1);
        rd("f40_e19", 9'd19, 32'hA527_A526);
        run_tx();
        chk("f40_skip_clr", bus.skipb, 1'b0);

        // 3 words, odd: nb=5
        send(3, 1'b1, 1'b0, 16'hA500);
        wait_txena("f3_txena");
`ifdef ETHTX_PAD_EN
        chk("f3_txcntb", bus.txcntb, 11'h7C4);
        rd("f3_e1", 9'd1, 32'h0000_A502);
        rd("f3_e7", 9'd7, 32'h0000_0000);
        rd("f3_e15", 9'd15, 32'h0000_0000);
`else
        chk("f3_txcntb", bus.txcntb, 11'h7FB);
        rd("f3_e1", 9'd1, 32'hA503_A502);
`endif
        rd("f3_e0", 9'd0, 32'hA501_A500);
        run_tx();

        // One odd word with skip: nb=0, silently dropped
        send(1, 1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nb0_txena", bus.txena, 1'b0);
            chk("nb0_tx_ok", bus.tx_ok, 1'b0);
        end
        chk("nb0_tx_ovf", bus.tx_ovf, 1'b0);
        chk("nb0_skipb", bus.skipb, 1'b0);
        chk("nb0_rdy", bus.wr_rdy, 1'b1);

        // 758 words: nb=1516 > 1514 on the last word
        send(758, 1'b0, 1'b0, 16'h5A00);
        tick();
        chk("ovf758_flag", bus.tx_ovf, 1'b1);
        chk("ovf758_txena", bus.txena, 1'b0);
        chk("ovf758_rdy", bus.wr_rdy, 1'b1);

        // 760 words: overflow mid-frame, tail words must be swallowed
        send(760, 1'b0, 1'b0, 16'h5A00);
        repeat (3) tick();
        chk("ovf760_flag", bus.tx_ovf, 1'b1);
        chk("ovf760_txena", bus.txena, 1'b0);

        // Next normal frame clears tx_ovf and sends
        send(30, 1'b0, 1'b0, 16'hA500);
        chk("post_ovf_clr", bus.tx_ovf, 1'b0);
        wait_txena("post_ovf_txena");
        chk("post_ovf_txcntb", bus.txcntb, 11'h7C4);
        rd("post_ovf_e0", 9'd0, 32'hA501_A500);
        run_tx();

        // Reset while waiting for txdone
        send(30, 1'b0, 1'b0, 16'hA500);
        wait_txena("rstw_txena");
        tick();
        tick();
        #2 clr_n = 1'b0;
        #1;
        chk("rstw_txena_async", bus.txena, 1'b0);
        chk("rstw_txcntb", bus.txcntb, 11'h000);
        chk("rstw_rdy", bus.wr_rdy, 1'b1);
        tick();
        clr_n = 1'b1;
        tick();
        chk("rstw_tx_ok", bus.tx_ok, 1'b0);
        chk("rstw_txena_after", bus.txena, 1'b0);
        chk("rstw_rdy_after", bus.wr_rdy, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ethtxbuf.md
ETHTXBUF -- requirements
Module: ethtxbuf

Interface
REQ-001 SHALL have parameter MAXB, default 11'd1514: maximum frame bytes accepted, excluding CRC.
REQ-002 SHALL have ports clk in 1 (clock, all logic on posedge); clr_n in 1 (reset, asynchronous, active-low).
REQ-003 SHALL have ports wr_stb in 1 (16-bit word write strobe); wr_data in 16 (word, low byte transmitted first); wr_last in 1 (qualifies the last word of the frame); wr_odd in 1 (valid with wr_last: only the low byte is valid).
REQ-004 SHALL have ports wr_skip in 1 (H-bit, sampled with the first word: the first byte is not sent); wr_rdy out 1 (block accepts words).
REQ-005 SHALL have ports txbaddr in 9 (read address from the sender); txbdata out 32 (buffer read data).
REQ-006 SHALL have ports txcntb out 11 (byte count for the sender); skipb out 1; txena out 1; txdone in 1.
REQ-007 SHALL have ports tx_ok out 1 (one-cycle pulse when a frame completes); tx_ovf out 1 (sticky oversize flag).

Function
REQ-008 SHALL hold a 512x32 frame buffer; word k SHALL be written to entry k>>1, bits [15:0] for even k and [31:16] for odd k.
REQ-009 SHALL register txbdata from buffer[txbaddr] on every posedge (latency 1).
REQ-010 SHALL implement FSM states FILL, PAD, ARM, WDONE, WREL.
REQ-011 FILL: wr_rdy=1; each wr_stb SHALL write one word and increment the word count.
REQ-011a FILL: wr_stb with wr_last SHALL go to PAD if PAD_EN is defined, else to ARM.
REQ-012 Byte count SHALL be nb = 2*words - wr_odd - skip; SHALL drive txcntb = (11'h800 - nb) mod 2048 and skipb = latched wr_skip.
REQ-013 If nb would exceed MAXB, SHALL set tx_ovf, discard the frame, clear the word count, and wait in FILL for a new first word; frame data SHALL be ignored up to and including wr_last.
REQ-014 ARM: wr_rdy=0; SHALL assert txena; SHALL go to WDONE.
REQ-015 WDONE: SHALL keep txena=1 until txdone=1, then drop txena and go to WREL.
REQ-016 WREL: SHALL wait for txdone=0, then pulse tx_ok, clear the word count and skip flag, and return to FILL.
REQ-017 wr_stb outside FILL SHALL be ignored (no write, no count change).
REQ-018 A frame of one word with wr_odd=1 and wr_skip=1 (nb=0) SHALL be dropped without transmission, with no tx_ok and no tx_ovf.
REQ-019 tx_ovf SHALL clear on the first accepted word of the next frame.

Reset
REQ-020 On clr_n low: state=FILL, txena=0, tx_ok=0, tx_ovf=0, skipb=0, txcntb=0, word count 0.
REQ-021 Buffer contents SHALL NOT be reset; txbdata is undefined until the first clock after reset release.
REQ-022 Reset during WDONE/WREL SHALL drop txena immediately; the sender sees txena=0 and returns to idle.

Configuration
REQ-023 Macro ETHTX_PAD_EN: when defined, PAD SHALL write 32'h0 to entries from the first unwritten half/entry through entry 15, one entry per cycle, then raise nb to 60 if below 60; then go to ARM.
REQ-023a ETHTX_PAD_EN: the zero writes SHALL include the upper half of a half-filled entry.
REQ-024 Without ETHTX_PAD_EN: PAD SHALL not exist, and short frames SHALL be sent at their real length.

Structure
REQ-025 Shared package ethpkg SHALL hold the state encodings, MAXB default, the minimum length 60, and buffer depth 512.
REQ-026 The buffer SHALL be sub-module ethtxram (512x32, two 16-bit half write enables, one registered read port).

Verification
REQ-027 30 words, no odd, no skip -> nb=60, txcntb=11'h7C4, txena high, txbdata at addr 0 = {w1,w0}.
REQ-028 3 words, wr_odd=1, PAD_EN defined -> entries 1..15 upper/lower zeroed, txcntb=11'h7C4; without PAD_EN -> txcntb=11'h7FB.
REQ-029 wr_skip=1, 40 words -> skipb=1, nb=79, txcntb=11'h7B1.
REQ-030 758 words -> tx_ovf=1, no txena, next 30-word frame sends normally and clears tx_ovf.
REQ-031 Handshake: txdone rises 5 cycles after txena -> txena falls next cycle; txdone held 3 cycles then falls -> tx_ok single pulse, wr_rdy=1.
REQ-032 clr_n low while in WDONE -> txena=0 asynchronously, state FILL, tx_ok stays 0.
